// File: rtl/add_sequencer.sv
// Multi-precision add/subtract sequencer: walks WORDS words through one external
// BUS_SIZE-bit adder, LS word first, chaining the carry through a register.
module add_sequencer #(
    parameter int BUS_SIZE = 16,
    parameter int WORDS    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      sub,
    input  logic [BUS_SIZE*WORDS-1:0] op_a,
    input  logic [BUS_SIZE*WORDS-1:0] op_b,
    output logic                      busy,
    output logic                      done,
    output logic [BUS_SIZE*WORDS-1:0] result,
    output logic                      carry_out,
    output logic                      zero,
    output logic [BUS_SIZE-1:0]       add_a,
    output logic [BUS_SIZE-1:0]       add_b,
    output logic                      add_c_in,
    input  logic [BUS_SIZE-1:0]       add_out,
    input  logic                      add_overflow
);
    localparam int W     = BUS_SIZE * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [W-1:0]     la, lb;
    logic             lsub;
    logic             carry;
    logic [W-1:0]     result_nxt;

    // Adder is driven only while a word is being processed
    always_comb begin
        add_a    = '0;
        add_b    = '0;
        add_c_in = 1'b0;
        if (state == RUN) begin
            add_a    = la[int'(idx)*BUS_SIZE +: BUS_SIZE];
            add_b    = lb[int'(idx)*BUS_SIZE +: BUS_SIZE] ^ {BUS_SIZE{lsub}};
            add_c_in = carry;
        end
    end

    // Full result as it will look after this cycle's word lands; zero is taken from it
    always_comb begin
        result_nxt = result;
        result_nxt[int'(idx)*BUS_SIZE +: BUS_SIZE] = add_out;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            la        <= '0;
            lb        <= '0;
            lsub      <= 1'b0;
            carry     <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            zero      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        la    <= op_a;
                        lb    <= op_b;
                        lsub  <= sub;
                        carry <= sub;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    result <= result_nxt;
                    carry  <= add_overflow;
                    if (idx == LAST) begin
                        carry_out <= add_overflow;
                        zero      <= (result_nxt == '0);
                        done      <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_add_sequencer.sv
// Bench for add_sequencer: models the external adder, scoreboards every accepted op
// against a full-width reference and checks busy/done cycle timing.
module tb_add_sequencer;
    localparam int BUS = 16;
    localparam int WDS = 4;
    localparam int W   = BUS * WDS;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           sub = 1'b0;
    logic [W-1:0]   op_a = '0, op_b = '0;
    logic           busy, done, carry_out, zero;
    logic [W-1:0]   result;
    logic [BUS-1:0] add_a, add_b, add_out;
    logic           add_c_in, add_overflow;

    typedef struct packed {
        logic [W-1:0] res;
        logic         cout;
        logic         z;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         tests = 0;
    int         fails = 0;
    logic [5:1] cin_seen;

    add_sequencer #(.BUS_SIZE(BUS), .WORDS(WDS)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .op_a(op_a), .op_b(op_b),
        .busy(busy), .done(done), .result(result), .carry_out(carry_out), .zero(zero),
        .add_a(add_a), .add_b(add_b), .add_c_in(add_c_in),
        .add_out(add_out), .add_overflow(add_overflow)
    );

    // external combinational ripple adder
    assign {add_overflow, add_out} = {1'b0, add_a} + {1'b0, add_b} + {{BUS{1'b0}}, add_c_in};

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        logic [W:0] full;
        exp_t       e;
        full   = s ? ({1'b0, a} + {1'b0, ~b} + (W+1)'(1)) : ({1'b0, a} + {1'b0, b});
        e.res  = full[W-1:0];
        e.cout = full[W];
        e.z    = (full[W-1:0] == '0);
        return e;
    endfunction

    // scoreboard pop on done; adder inputs must be quiet whenever not busy
    always @(negedge clk) begin
        if (!rst) begin
            if (!busy) chk("add_idle", W'({add_a, add_b, add_c_in}), '0);
            if (done) begin
                chk("done_has_op", W'(sb.size() > 0), W'(1));
                if (sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    chk("result", result, mon_e.res);
                    chk("carry_out", W'(carry_out), W'(mon_e.cout));
                    chk("zero", W'(zero), W'(mon_e.z));
                end
            end
        end
    end

    // Accept at the next edge T, then check busy/done over T+1..T+5; poke[n]
    // drives start with junk operands into edge T+n.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input logic [5:1] poke);
        @(negedge clk);
        chk("idle_busy", W'(busy), '0);
        chk("idle_done", W'(done), '0);
        start = 1'b1; op_a = a; op_b = b; sub = s;
        sb.push_back(model(a, b, s));
        @(posedge clk);
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            chk($sformatf("busy_c%0d", n), W'(busy), W'(1));
            chk($sformatf("done_c%0d", n), W'(done), W'(n == 5));
            cin_seen[n] = add_c_in;
            start = poke[n];
            op_a  = {$urandom, $urandom};
            op_b  = {$urandom, $urandom};
            sub   = 1'($urandom);
        end
    endtask

    initial begin
        #2;
        chk("rst_busy", W'(busy), '0);
        chk("rst_done", W'(done), '0);
        chk("rst_result", result, '0);
        chk("rst_flags", W'({carry_out, zero}), '0);
        chk("rst_add", W'({add_a, add_b, add_c_in}), '0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        run_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, '0);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, '0);
        chk("cin_first", W'(cin_seen[1]), '0);
        chk("cin_rest", W'(cin_seen[4:2]), W'(3'b111));
        run_op(64'd5, 64'd7, 1'b1, '0);
        chk("sub_cin_first", W'(cin_seen[1]), W'(1));
        run_op(64'd7, 64'd5, 1'b1, '0);

        // starts at T+2 and T+5 are ignored; the following run_op accepts at T+6
        run_op(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 5'b10010);
        run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, '0);
        start = 1'b0;

        // async reset between T+2 and T+3
        @(negedge clk);
        start = 1'b1; op_a = 64'hAAAA; op_b = 64'h5555; sub = 1'b0;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("midrst_busy", W'(busy), '0);
        chk("midrst_done", W'(done), '0);
        chk("midrst_result", result, '0);
        chk("midrst_add", W'({add_a, add_b, add_c_in}), '0);
        sb.delete();
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        run_op(64'd3, 64'd4, 1'b0, '0);

        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] ra, rb;
            logic [5:1]   pk;
            ra = {$urandom, $urandom};
            rb = ($urandom_range(0, 7) == 0) ? ra : {$urandom, $urandom};
            pk = 5'($urandom);
            run_op(ra, rb, 1'($urandom), pk);
        end
        start = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("sb_drained", W'(sb.size()), '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/add_sequencer.md
# add_sequencer

Multi-precision add/subtract sequencer that drives one shared BUS_SIZE-bit ripple Adder over WORDS consecutive cycles to produce a WORDS×BUS_SIZE-bit sum or difference, least-significant word first. The carry is chained between words through a register. The Adder instance sits outside this block and connects through the add_* ports. The ALU control issues operations with a start/busy/done handshake.

## Interface
- BUS_SIZE, 16, width of the shared Adder and of one operand word.
- WORDS, 4, number of words per operand (≥2); full operand width W = BUS_SIZE*WORDS.
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous and active-high.
- start  input  1  request an operation; accepted only in IDLE.
- sub  input  1  0 = A+B, 1 = A−B; sampled with start.
- op_a  input  W  operand A; sampled with start.
- op_b  input  W  operand B; sampled with start.
- busy  output  1  high from the cycle after acceptance until done (inclusive).
- done  output  1  one-cycle pulse; result/carry_out/zero valid.
- result  output  W  sum/difference register.
- carry_out  output  1  final carry (for sub: 1 = no borrow).
- zero  output  1  result == 0, valid with done and held after.
- add_a  output  BUS_SIZE  to Adder a.
- add_b  output  BUS_SIZE  to Adder b.
- add_c_in  output  1  to Adder c_in.
- add_out  input  BUS_SIZE  from Adder out.
- add_overflow  input  1  from Adder overflow (carry out of MSB).

## Operation
- Registers: state, idx (word index, ceil(log2 WORDS) bits), la/lb (latched operands, W each), lsub, carry, result, carry_out, zero.
- FSM:
  - IDLE: if start, latch op_a→la, op_b→lb, sub→lsub. Set carry←sub, idx←0, go to RUN. Otherwise stay in IDLE.
  - RUN: add_a = la word idx. add_b = lb word idx, XORed with {BUS_SIZE{lsub}}. add_c_in = carry.
    - Each cycle: result word idx←add_out, carry←add_overflow.
    - If idx==WORDS−1: go to DONE, set carry_out←add_overflow. Otherwise idx←idx+1.
  - DONE: done=1 for this cycle only. zero = (result==0). Go to IDLE.
- add_a, add_b and add_c_in are combinational from registers only; they are 0 in IDLE and DONE.
- The Adder is purely combinational. Its output is captured in the same cycle it is driven.
- Arithmetic is modulo 2^W. Subtraction is A + ~B + 1, using the two's-complement inversion and initial carry.
- start is ignored in RUN and DONE; it is not queued. The op_* inputs are don't-care outside the accept cycle.
- result, carry_out and zero hold their values from done until the next accepted start. During RUN, result is partially updated and is not valid.

## Timing
- Reset (asynchronous, any time): state=IDLE, idx=0. busy, done, result, carry_out, zero, carry, la, lb and lsub all become 0. add_* outputs become 0.
- Reset mid-operation aborts with no done pulse. The first start accepted after rst deasserts behaves normally.
- start sampled high in IDLE at edge T:
  - RUN occupies cycles T+1 … T+WORDS (one word per cycle).
  - DONE and the done pulse occur at cycle T+WORDS+1.
  - busy is high during cycles T+1 … T+WORDS+1.
  - IDLE resumes at T+WORDS+2; the earliest next accept is at that edge.
- Latency is WORDS+1 cycles from accept to done; throughput is one operation per WORDS+2 cycles.
- start held high continuously produces back-to-back operations, each accepted on entering IDLE.
- busy and done are registered-state decodes and have no combinational path from start.

## Test plan
- Add, WORDS=4: A=0x0000_0000_0000_FFFF, B=0x1, start at T → result=0x0000_0000_0001_0000, carry_out=0, zero=0, done only at T+5, busy high T+1..T+5.
- Full wrap: A=0xFFFF_FFFF_FFFF_FFFF, B=0x1, sub=0 → result=0, carry_out=1, zero=1; add_c_in observed 0 in the first RUN cycle and 1 in the following RUN cycles.
- Subtract: A=5, B=7, sub=1 → result=0xFFFF_FFFF_FFFF_FFFE, carry_out=0. Then A=7, B=5 → result=2, carry_out=1.
- Start while busy: pulse start with different operands at T+2 and at T+5 (during DONE) → both ignored, result unchanged. A start at T+6 is accepted, with done at T+11.
- Reset mid-operation: assert rst asynchronously between T+2 and T+3 → busy=0, result=0 immediately, no done pulse. After release, a new add of 3+4 gives result=7 with done 5 cycles after accept.
- Randomized: 1000 random (A,B,sub) against a W-bit reference model → result, carry_out and zero match on every done; add_* are 0 whenever busy=0.
